// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             IRWrite;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             IorD;
    logic             MemtoReg;
    logic             RegDst;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             illegal_op;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  opcode, mem_ready,
        output IRWrite, RegWrite, MemRead, MemWrite, IorD, MemtoReg, RegDst, ALUSrcA,
               ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond, illegal_op, state_dbg,
               instr_retired
    );

    modport slave (
        output opcode, mem_ready,
        input  IRWrite, RegWrite, MemRead, MemWrite, IorD, MemtoReg, RegDst, ALUSrcA,
               ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond, illegal_op, state_dbg,
               instr_retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: one state per cycle, stalls on
// mem_ready in FETCH/MEMRD/MEMWR, and counts retired instructions.
module multicycle_control #(
    parameter logic [5:0]  OP_RTYPE = 6'h00,
    parameter logic [5:0]  OP_LW    = 6'h23,
    parameter logic [5:0]  OP_SW    = 6'h2B,
    parameter logic [5:0]  OP_BEQ   = 6'h04,
    parameter logic [5:0]  OP_J     = 6'h02,
    parameter logic [5:0]  OP_ADDI  = 6'h08,
    parameter int unsigned CNT_W    = 32
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_control_if.master  bus
);

    localparam logic [3:0] StStart  = 4'd0;
    localparam logic [3:0] StFetch  = 4'd1;
    localparam logic [3:0] StDecode = 4'd2;
    localparam logic [3:0] StMemAdr = 4'd3;
    localparam logic [3:0] StMemRd  = 4'd4;
    localparam logic [3:0] StMemWb  = 4'd5;
    localparam logic [3:0] StMemWr  = 4'd6;
    localparam logic [3:0] StExec   = 4'd7;
    localparam logic [3:0] StAluWb  = 4'd8;
    localparam logic [3:0] StBranch = 4'd9;
    localparam logic [3:0] StAddiEx = 4'd10;
    localparam logic [3:0] StAddiWb = 4'd11;
    localparam logic [3:0] StJump   = 4'd12;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StStart:  state_d = StFetch;
            StFetch:  if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_d = StMemAdr;
                else if (bus.opcode == OP_RTYPE)                state_d = StExec;
                else if (bus.opcode == OP_BEQ)                  state_d = StBranch;
                else if (bus.opcode == OP_ADDI)                 state_d = StAddiEx;
                else if (bus.opcode == OP_J)                    state_d = StJump;
                else                                            state_d = StFetch;
            end
            StMemAdr: state_d = (bus.opcode == OP_SW) ? StMemWr : StMemRd;
            StMemRd:  if (bus.mem_ready) state_d = StMemWb;
            StMemWr: begin
                if (bus.mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StAluWb, StBranch, StAddiWb, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default:  state_d = StFetch;
        endcase
    end

    assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StStart;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode from the registered state so reset clears them without an edge.
    always_comb begin
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.illegal_op  = 1'b0;
        case (state_q)
            StFetch: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            StDecode: begin
                bus.ALUSrcB    = 2'b11;
                bus.illegal_op = !(bus.opcode == OP_LW || bus.opcode == OP_SW ||
                                   bus.opcode == OP_RTYPE || bus.opcode == OP_BEQ ||
                                   bus.opcode == OP_ADDI || bus.opcode == OP_J);
            end
            StMemAdr, StAddiEx: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            StMemRd: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            StMemWb: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            StMemWr: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            StExec: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            StAluWb: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            StBranch: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end
            StAddiWb: bus.RegWrite = 1'b1;
            StJump: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.state_dbg     = state_q;
    assign bus.instr_retired = cnt_q;

endmodule
